// File: rtl/song_player.sv
// Table-driven tone sequencer: plays a stored list of {beats, half-period} notes as a square wave.
// Commands are stop, then pause, then start, in that order of priority.
module song_player #(
    parameter int TICK_CYCLES = 12000000,
    parameter int NOTE_W      = 17,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NOTE_W+3:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_idx,
    output logic              beep,
    output logic              busy,
    output logic              paused,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PLAY  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NOTE_W+3:0] r_table [DEPTH];
    logic [NOTE_W+3:0] w_entry;
    logic [NOTE_W-1:0] r_hp;
    logic [NOTE_W-1:0] w_hp_nxt;
    logic [NOTE_W-1:0] r_tone_cnt;
    logic [NOTE_W-1:0] w_tone_cnt_nxt;
    logic              r_tone;
    logic              w_tone_nxt;
    logic [TICK_W-1:0] r_beat_cnt;
    logic [TICK_W-1:0] w_beat_cnt_nxt;
    logic [4:0]        r_beats_left;
    logic [4:0]        w_beats_left_nxt;
    logic [ADDR_W-1:0] r_note_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_note_end;
    logic              w_at_last;
    logic              w_done;
    logic              r_beep;
    logic              r_busy;
    logic              r_paused;
    logic              r_done;

    // Song table storage; intentionally not reset so a song survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    assign w_entry   = r_table[r_note_idx];
    assign w_at_last = (r_note_idx == last_idx);

    // Counter, tone-phase and index next values for the current state.
    always_comb begin
        w_hp_nxt         = r_hp;
        w_tone_cnt_nxt   = r_tone_cnt;
        w_tone_nxt       = r_tone;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_beats_left_nxt = r_beats_left;
        w_idx_nxt        = r_note_idx;
        w_note_end       = 1'b0;
        w_done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_idx_nxt = '0;
                end else begin
                    w_idx_nxt = r_note_idx;
                end
            end
            S_LOAD: begin
                w_hp_nxt       = w_entry[NOTE_W-1:0];
                w_tone_cnt_nxt = '0;
                w_tone_nxt     = 1'b0;
                w_beat_cnt_nxt = '0;
                // A zero duration field encodes the longest note, 16 beats.
                if (w_entry[NOTE_W+3:NOTE_W] == 4'd0) begin
                    w_beats_left_nxt = 5'd16;
                end else begin
                    w_beats_left_nxt = {1'b0, w_entry[NOTE_W+3:NOTE_W]};
                end
            end
            S_PLAY: begin
                if (r_hp == '0) begin
                    w_tone_cnt_nxt = '0;
                    w_tone_nxt     = 1'b0;
                end else if (r_tone_cnt == r_hp - NOTE_W'(1)) begin
                    w_tone_cnt_nxt = '0;
                    w_tone_nxt     = ~r_tone;
                end else begin
                    w_tone_cnt_nxt = r_tone_cnt + NOTE_W'(1);
                end
                if (r_beat_cnt == TICK_LAST) begin
                    w_beat_cnt_nxt   = '0;
                    w_beats_left_nxt = r_beats_left - 5'd1;
                    w_note_end       = (r_beats_left == 5'd1);
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + TICK_W'(1);
                end
                if (w_note_end && !stop) begin
                    if (!w_at_last) begin
                        w_idx_nxt = r_note_idx + ADDR_W'(1);
                    end else if (loop_en) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_done = 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_note_idx;
                end
            end
            S_PAUSE: begin
                w_idx_nxt = r_note_idx;
            end
            default: begin
                w_idx_nxt = r_note_idx;
            end
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_note_end) begin
                    w_state_nxt = (w_at_last && !loop_en) ? S_IDLE : S_LOAD;
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs, aligned with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp         <= '0;
            r_tone_cnt   <= '0;
            r_tone       <= 1'b0;
            r_beat_cnt   <= '0;
            r_beats_left <= 5'd0;
            r_note_idx   <= '0;
            r_beep       <= 1'b0;
            r_busy       <= 1'b0;
            r_paused     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_hp         <= w_hp_nxt;
            r_tone_cnt   <= w_tone_cnt_nxt;
            r_tone       <= w_tone_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_note_idx   <= w_idx_nxt;
            r_beep       <= (w_state_nxt == S_PLAY) ? w_tone_nxt : 1'b0;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_paused     <= (w_state_nxt == S_PAUSE);
            r_done       <= w_done;
        end
    end

    assign beep     = r_beep;
    assign busy     = r_busy;
    assign paused   = r_paused;
    assign note_idx = r_note_idx;
    assign done     = r_done;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a 20-cycle beat; expected waveforms are derived from cycle counts.
module tb_song_player;

    localparam int TICK = 20;
    localparam int NW   = 17;
    localparam int AW   = 6;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NW+3:0] wr_data;
    logic          start;
    logic          stop;
    logic          pause;
    logic          loop_en;
    logic [AW-1:0] last_idx;
    logic          beep;
    logic          busy;
    logic          paused;
    logic [AW-1:0] note_idx;
    logic          done;

    int n_checks;
    int n_fail;

    song_player #(.TICK_CYCLES(TICK), .NOTE_W(NW), .DEPTH(64), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .pause(pause), .loop_en(loop_en), .last_idx(last_idx),
        .beep(beep), .busy(busy), .paused(paused), .note_idx(note_idx), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [3:0] d, input logic [NW-1:0] h);
        wr_addr = a;
        wr_data = {d, h};
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_song();
        write_entry(6'd0, 4'd2, 17'd5);
        write_entry(6'd1, 4'd1, 17'd0);
        write_entry(6'd2, 4'd1, 17'd4);
    endtask

    function automatic logic tone_at(input int k, input int hp);
        return ((k / hp) % 2) == 1;
    endfunction

    // Expected beep of the 3-note song at cycle c (c=0 is the first LOAD).
    function automatic logic song_beep(input int c);
        if (c >= 1 && c <= 40) return tone_at(c - 1, 5);
        if (c >= 63 && c <= 82) return tone_at(c - 63, 4);
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] song_idx(input int c);
        if (c <= 40) return 6'd0;
        if (c <= 61) return 6'd1;
        return 6'd2;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({beep, busy, paused, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outs got %b exp 0000", {beep, busy, paused, done});
        end
        n_checks++;
        if (note_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_idx got %0d exp 0", note_idx);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_note();
        int n_done;
        n_done = 0;
        write_entry(6'd0, 4'd1, 17'd3);
        last_idx = 6'd0;
        loop_en  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 23; c++) begin
            if (c > 0) tick();
            if (done === 1'b1) n_done++;
            n_checks++;
            if (beep !== ((c >= 1 && c <= 20) ? tone_at(c - 1, 3) : 1'b0)) begin
                n_fail++;
                $display("FAIL single_beep c=%0d got %b", c, beep);
            end
            n_checks++;
            if (busy !== (c <= 20)) begin
                n_fail++;
                $display("FAIL single_busy c=%0d got %b exp %b", c, busy, (c <= 20));
            end
            n_checks++;
            if (done !== (c == 21)) begin
                n_fail++;
                $display("FAIL single_done c=%0d got %b exp %b", c, done, (c == 21));
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL single_done_count got %0d exp 1", n_done);
        end
    endtask

    task automatic test_song(input logic lp);
        logic          exp_beep;
        logic          exp_busy;
        logic          exp_done;
        logic [AW-1:0] exp_idx;
        load_song();
        last_idx = 6'd2;
        loop_en  = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 84; c++) begin
            if (c > 0) tick();
            exp_beep = song_beep(c);
            exp_idx  = song_idx(c);
            exp_busy = 1'b1;
            exp_done = 1'b0;
            if (c >= 83) begin
                exp_beep = 1'b0;
                exp_idx  = lp ? 6'd0 : 6'd2;
                exp_busy = lp;
                exp_done = !lp && (c == 83);
            end
            n_checks++;
            if (beep !== exp_beep) begin
                n_fail++;
                $display("FAIL song%0b_beep c=%0d got %b exp %b", lp, c, beep, exp_beep);
            end
            n_checks++;
            if (note_idx !== exp_idx) begin
                n_fail++;
                $display("FAIL song%0b_idx c=%0d got %0d exp %0d", lp, c, note_idx, exp_idx);
            end
            n_checks++;
            if ({busy, done} !== {exp_busy, exp_done}) begin
                n_fail++;
                $display("FAIL song%0b_busy_done c=%0d got %b exp %b", lp, c, {busy, done}, {exp_busy, exp_done});
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic test_pause();
        int   k;
        logic exp_beep;
        write_entry(6'd0, 4'd2, 17'd3);
        last_idx = 6'd0;
        loop_en  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) tick();
            k = (c <= 10) ? c - 1 : c - 8;
            exp_beep = ((c >= 1 && c <= 10) || (c >= 18 && c <= 47)) ? tone_at(k, 3) : 1'b0;
            n_checks++;
            if (beep !== exp_beep) begin
                n_fail++;
                $display("FAIL pause_beep c=%0d got %b exp %b", c, beep, exp_beep);
            end
            n_checks++;
            if (paused !== (c >= 11 && c <= 17)) begin
                n_fail++;
                $display("FAIL pause_flag c=%0d got %b", c, paused);
            end
            n_checks++;
            if ({busy, done} !== {(c <= 47), (c == 48)}) begin
                n_fail++;
                $display("FAIL pause_busy_done c=%0d got %b exp %b", c, {busy, done}, {(c <= 47), (c == 48)});
            end
            if (c == 10) pause = 1'b1;
            if (c == 17) pause = 1'b0;
        end
    endtask

    task automatic test_stop();
        load_song();
        last_idx = 6'd2;
        loop_en  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 45; c++) tick();
        n_checks++;
        if (note_idx !== 6'd1) begin
            n_fail++;
            $display("FAIL stop_pre_idx got %0d exp 1", note_idx);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({busy, beep, done, note_idx} !== {3'b000, 6'd1}) begin
            n_fail++;
            $display("FAIL stop_now got %b exp 000000001", {busy, beep, done, note_idx});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL stop_idle i=%0d got %b exp 00", i, {busy, done});
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_start_same got %b exp 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, note_idx} !== {1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL stop_restart got %b exp 1000000", {busy, note_idx});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset_midsong();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 75; c++) tick();
        n_checks++;
        if ({beep, busy, note_idx} !== {2'b11, 6'd2}) begin
            n_fail++;
            $display("FAIL rst_pre got %b exp 11000010", {beep, busy, note_idx});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({beep, busy, paused, done, note_idx} !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_async got %b exp 0", {beep, busy, paused, done, note_idx});
        end
        start = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_ignored got %b exp 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if ({busy, note_idx} !== 7'd0) begin
            n_fail++;
            $display("FAIL rst_release_idle got %b exp 0", {busy, note_idx});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 41; c++) tick();
        n_checks++;
        if ({busy, note_idx} !== {1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL rst_table_kept got %b exp 1000001", {busy, note_idx});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        loop_en  = 1'b0;
        last_idx = '0;
        test_reset();
        test_single_note();
        test_song(1'b0);
        test_song(1'b1);
        test_pause();
        test_stop();
        test_reset_midsong();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
